// File: rtl/phoneme_queue_sequencer_if.sv
// CPU-side bus bundle for phoneme_queue_sequencer: 68000-style strobes, register select, data and dtack.
// Latency: none, this is wiring only.
// Backpressure: the slave withholds VoiceDtack_L; the master holds AS_L low until dtack is seen.
// Ports: VoiceControl_H/AS_L/UDS_L/LDS_L/RW/Address/DataIn driven by the CPU (master);
//        DataOut/VoiceDtack_L driven by the sequencer (slave).
interface phoneme_queue_sequencer_if;
    logic        VoiceControl_H;
    logic        AS_L;
    logic        UDS_L;
    logic        LDS_L;
    logic        RW;
    logic [1:0]  Address;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        VoiceDtack_L;

    modport master (
        output VoiceControl_H, AS_L, UDS_L, LDS_L, RW, Address, DataIn,
        input  DataOut, VoiceDtack_L
    );

    modport slave (
        input  VoiceControl_H, AS_L, UDS_L, LDS_L, RW, Address, DataIn,
        output DataOut, VoiceDtack_L
    );
endinterface

// File: rtl/phoneme_queue_sequencer.sv
// Phoneme FIFO written by the CPU and a sequencer that plays entries one at a time to the synthesizer.
// Latency: dtack one cycle after the accepted bus cycle; a pop in IDLE gives a start pulse the next cycle.
// Backpressure: a push to a full FIFO withholds VoiceDtack_L until a pop frees a slot.
// Ports: Clock50Mhz/RESET_H (sync, active high); bus (slave modport of phoneme_queue_sequencer_if);
//        phoneme_sel/start_phoneme_output to the synthesizer; phoneme_speech_busy/finish from it;
//        Voice_IRQ_L only when PHONEME_QUEUE_IRQ_EN is defined (drain interrupt, status bit 11).
module phoneme_queue_sequencer #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                     Clock50Mhz,
    input  logic                     RESET_H,
    phoneme_queue_sequencer_if.slave bus,
    output logic [7:0]               phoneme_sel,
    output logic                     start_phoneme_output,
    input  logic                     phoneme_speech_busy,
    input  logic                     phoneme_speech_finish
`ifdef PHONEME_QUEUE_IRQ_EN
    ,
    output logic                     Voice_IRQ_L
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    // Registered state
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pause_q, pause_d;
    logic          ack_done_q, ack_done_d;
    logic          dtack_n_q, dtack_n_d;
    logic [15:0]   data_out_q, data_out_d;
    state_t        state_q, state_d;
    logic [7:0]    sel_q, sel_d;
    logic          start_q, start_d;
    logic [TW-1:0] tmr_q, tmr_d;

    // Combinational helpers
    logic        full, empty;
    logic        bus_sel, push_req, bus_act;
    logic        push_eff, pop, flush, stat_rd;
    logic        timeout_hit;
    logic [15:0] status, rd_data;
    logic        unused_in;

    // Upper strobe and upper data byte carry nothing this block uses.
    assign unused_in = ^{bus.UDS_L, bus.DataIn[15:8]};

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);

    // ack_done_q keeps a held AS_L from being treated as a second bus cycle.
    assign bus_sel  = bus.VoiceControl_H && !bus.AS_L && !ack_done_q;
    assign push_req = bus_sel && !bus.RW && (bus.Address == 2'd0) && !bus.LDS_L;
    // A push into a full FIFO is simply not accepted yet: no action, no ack, retried every cycle.
    assign bus_act  = bus_sel && !(push_req && full);
    assign flush    = bus_act && !bus.RW && (bus.Address == 2'd1) && bus.DataIn[0];
    assign push_eff = push_req && !full && !flush;
    assign stat_rd  = bus_act && bus.RW && (bus.Address == 2'd0);
    assign pop      = (state_q == S_IDLE) && !empty && !pause_q;

    assign timeout_hit = (state_q == S_WAIT_BUSY) && !phoneme_speech_busy && (tmr_q == TMR_LAST);

`ifdef PHONEME_QUEUE_IRQ_EN
    logic irq_q, irq_d, irq_set;
    // Drain is judged on the FIFO contents as IDLE is entered.
    assign irq_set = ((state_q == S_GAP) || timeout_hit) && (count_d == '0);

    always_comb begin
        irq_d = irq_q;
        if (stat_rd) irq_d = 1'b0;
        if (irq_set) irq_d = 1'b1;
    end

    assign Voice_IRQ_L = ~irq_q;
`endif

    always_comb begin
        status        = '0;
        status[15]    = full;
        status[14]    = empty;
        status[13]    = (state_q != S_IDLE);
        status[12]    = pause_q;
`ifdef PHONEME_QUEUE_IRQ_EN
        status[11]    = irq_q;
`endif
        status[4:0]   = 5'(count_q);
    end

    always_comb begin
        case (bus.Address)
            2'd0:    rd_data = status;
            2'd1:    rd_data = {14'b0, pause_q, 1'b0};
            default: rd_data = 16'h0000;
        endcase
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pause_d    = pause_q;
        ack_done_d = ack_done_q;
        dtack_n_d  = dtack_n_q;
        data_out_d = data_out_q;
        state_d    = state_q;
        sel_d      = sel_q;
        start_d    = 1'b0;
        tmr_d      = tmr_q;

        // Bus handshake: one action per AS_L assertion, dtack held until AS_L rises.
        if (bus.AS_L) begin
            ack_done_d = 1'b0;
            dtack_n_d  = 1'b1;
            data_out_d = 16'h0000;
        end else if (bus_act) begin
            ack_done_d = 1'b1;
            dtack_n_d  = 1'b0;
            if (bus.RW) data_out_d = rd_data;
        end

        if (bus_act && !bus.RW && (bus.Address == 2'd1)) begin
            pause_d = bus.DataIn[1];
        end

        // FIFO: flush overrides everything; the word being popped this cycle still plays.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                mem_d[wr_ptr_q] = bus.DataIn[7:0];
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_eff) - CW'(pop);
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    sel_d   = mem_q[rd_ptr_q];
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                tmr_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (phoneme_speech_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timeout_hit) begin
                    // Synthesizer never acknowledged: drop the phoneme and move on.
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!phoneme_speech_busy && phoneme_speech_finish) state_d = S_GAP;
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock50Mhz) begin
        if (RESET_H) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pause_q    <= 1'b0;
            ack_done_q <= 1'b0;
            dtack_n_q  <= 1'b1;
            data_out_q <= 16'h0000;
            state_q    <= S_IDLE;
            sel_q      <= 8'h00;
            start_q    <= 1'b0;
            tmr_q      <= '0;
`ifdef PHONEME_QUEUE_IRQ_EN
            irq_q      <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pause_q    <= pause_d;
            ack_done_q <= ack_done_d;
            dtack_n_q  <= dtack_n_d;
            data_out_q <= data_out_d;
            state_q    <= state_d;
            sel_q      <= sel_d;
            start_q    <= start_d;
            tmr_q      <= tmr_d;
`ifdef PHONEME_QUEUE_IRQ_EN
            irq_q      <= irq_d;
`endif
        end
        // Storage needs no reset; the pointers define what is valid.
        mem_q <= mem_d;
    end

    assign bus.VoiceDtack_L         = dtack_n_q;
    assign bus.DataOut              = data_out_q;
    assign phoneme_sel              = sel_q;
    assign start_phoneme_output     = start_q;

endmodule

// File: tb/tb_phoneme_queue_sequencer.sv
// Bench for phoneme_queue_sequencer: directed scenarios plus a random push/read mix.
// Latency: n/a.
// Backpressure: bus tasks wait on VoiceDtack_L with bounded cycle budgets.
module tb_phoneme_queue_sequencer;
    localparam int DEPTH = 16;
    localparam int TO    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sel;
    logic       start;
    logic       busy = 1'b0;
    logic       finish = 1'b1;
`ifdef PHONEME_QUEUE_IRQ_EN
    logic       irq_l;
`endif

    always #5 clk = ~clk;

    phoneme_queue_sequencer_if bus_if();

    phoneme_queue_sequencer #(.DEPTH(DEPTH), .BUSY_TIMEOUT(TO)) dut (
        .Clock50Mhz           (clk),
        .RESET_H              (rst),
        .bus                  (bus_if),
        .phoneme_sel          (sel),
        .start_phoneme_output (start),
        .phoneme_speech_busy  (busy),
        .phoneme_speech_finish(finish)
`ifdef PHONEME_QUEUE_IRQ_EN
        ,
        .Voice_IRQ_L          (irq_l)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phonemes accepted by the FIFO but not yet started, in order.
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         n_starts = 0;
    int         last_start_cyc = 0;
    int         last_gap = 0;
    logic [7:0] last_played = 8'h00;
    logic [7:0] prev_sel = 8'h00;
    logic       prev_start = 1'b0;
    logic [7:0] mon_exp;

    // Busy model: 0 = respond to each start, 1 = hold low, 2 = hold high.
    int busy_mode = 0;
    bit bm_fixed  = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] stat(input int cnt, input bit active, input bit paused, input bit irq);
        logic [4:0] c5;
        c5 = 5'(cnt);
        return {cnt == DEPTH, cnt == 0, active, paused, irq, 6'b0, c5};
    endfunction

    task automatic check_stat(input string nm, input logic [15:0] act, input logic [15:0] exp);
`ifdef PHONEME_QUEUE_IRQ_EN
        check(nm, act & 16'hF7FF, exp & 16'hF7FF);
`else
        check(nm, act, exp);
`endif
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            prev_sel   = 8'h00;
            prev_start = 1'b0;
        end else begin
            if (start) begin
                check("start_one_cycle", prev_start, 1'b0);
                if (n_starts > 0) begin
                    last_gap = cyc - last_start_cyc;
                    check("start_spacing_ge4", last_gap >= 4, 1);
                end
                last_start_cyc = cyc;
                n_starts++;
                last_played = sel;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_start: sel=%0h with nothing queued (cycle %0d)", sel, cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("phoneme_sel_order", sel, mon_exp);
                end
            end else begin
                check("phoneme_sel_stable", sel, prev_sel);
            end
            if (bus_if.VoiceDtack_L) check("dataout_zero_without_ack", bus_if.DataOut, 16'h0000);
            prev_sel   = sel;
            prev_start = start;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (busy_mode == 1) busy = 1'b0;
            else if (busy_mode == 2) busy = 1'b1;
            else if (start && !rst) begin
                int d, l;
                d = bm_fixed ? 3 : int'($urandom_range(1, 4));
                l = bm_fixed ? 20 : int'($urandom_range(1, 8));
                repeat (d) @(negedge clk);
                busy = 1'b1;
                repeat (l) @(negedge clk);
                busy = 1'b0;
            end
        end
    end

    task automatic bus_idle();
        bus_if.VoiceControl_H = 1'b0;
        bus_if.AS_L           = 1'b1;
        bus_if.UDS_L          = 1'b1;
        bus_if.LDS_L          = 1'b1;
        bus_if.RW             = 1'b1;
        bus_if.Address        = 2'd0;
        bus_if.DataIn         = 16'h0000;
    endtask

    task automatic bus_cycle(input logic rw, input logic [1:0] addr, input logic [15:0] din,
                             input logic lds, input bit is_push, input bit chk_lat,
                             output logic [15:0] dout);
        int lat, rel;
        @(negedge clk);
        bus_if.VoiceControl_H = 1'b1;
        bus_if.AS_L           = 1'b0;
        bus_if.UDS_L          = 1'b0;
        bus_if.LDS_L          = lds;
        bus_if.RW             = rw;
        bus_if.Address        = addr;
        bus_if.DataIn         = din;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus_if.VoiceDtack_L && lat < 400);
        check("bus_ack_within_budget", bus_if.VoiceDtack_L, 1'b0);
        if (!bus_if.VoiceDtack_L && is_push) exp_q.push_back(din[7:0]);
        if (chk_lat) check("dtack_assert_latency", lat, 1);
        dout = bus_if.DataOut;
        bus_idle();
        rel = 0;
        do begin
            @(negedge clk);
            rel++;
        end while (!bus_if.VoiceDtack_L && rel < 8);
        check("dtack_release_latency", rel, 1);
    endtask

    task automatic push(input logic [7:0] v);
        logic [15:0] d;
        bus_cycle(1'b0, 2'd0, {8'($urandom), v}, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [15:0] data);
        logic [15:0] d;
        bus_cycle(1'b0, addr, data, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic rd(input logic [1:0] addr, output logic [15:0] data);
        bus_cycle(1'b1, addr, 16'h0000, 1'b0, 1'b0, 1'b1, data);
    endtask

    task automatic push_withheld(input logic [7:0] v);
        @(negedge clk);
        bus_if.VoiceControl_H = 1'b1;
        bus_if.AS_L           = 1'b0;
        bus_if.UDS_L          = 1'b0;
        bus_if.LDS_L          = 1'b0;
        bus_if.RW             = 1'b0;
        bus_if.Address        = 2'd0;
        bus_if.DataIn         = {8'h00, v};
        repeat (10) begin
            @(negedge clk);
            check("full_push_withheld", bus_if.VoiceDtack_L, 1'b1);
        end
        bus_idle();
        @(negedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("drain_within_budget", exp_q.size(), 0);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] r;
        int n0, k;
        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dtack", bus_if.VoiceDtack_L, 1'b1);
        check("reset_dataout", bus_if.DataOut, 16'h0000);
        check("reset_phoneme_sel", sel, 8'h00);
        check("reset_start", start, 1'b0);
`ifdef PHONEME_QUEUE_IRQ_EN
        check("reset_irq", irq_l, 1'b1);
`endif
        rst = 1'b0;
        @(negedge clk);

        rd(2'd0, r);
        check_stat("status_after_reset", r, 16'h4000);

        // Three phonemes with a fixed busy profile.
        busy_mode = 0;
        bm_fixed  = 1'b1;
        n0 = n_starts;
        push(8'h15);
        push(8'h2A);
        push(8'h07);
        drain();
        check("three_starts", n_starts - n0, 3);
        check("last_played_07", last_played, 8'h07);
        check("fixed_busy_gap", last_gap, 26);
        rd(2'd0, r);
        check_stat("status_after_three", r, 16'h4000);

        // Pause, fill, stall the 17th push, then release.
        bm_fixed = 1'b0;
        wr(2'd1, 16'h0002);
        rd(2'd1, r);
        check("pause_readback", r, 16'h0002);
        for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i));
        rd(2'd0, r);
        check_stat("status_full_paused", r, 16'h9010);
        push_withheld(8'h33);
        rd(2'd0, r);
        check_stat("status_full_after_abort", r, stat(DEPTH, 0, 1, 0));
        wr(2'd1, 16'h0000);
        push(8'h33);
        drain();
        check("last_played_33", last_played, 8'h33);
        rd(2'd0, r);
        check_stat("status_after_full_drain", r, 16'h4000);

        // Busy never rises: each phoneme times out.
        busy_mode = 1;
        n0 = n_starts;
        wr(2'd1, 16'h0002);
        push(8'h01);
        push(8'h02);
        wr(2'd1, 16'h0000);
        drain();
        check("timeout_two_starts", n_starts - n0, 2);
        check("timeout_gap", last_gap, TO + 2);
        busy_mode = 0;
        push(8'h03);
        drain();
        check("after_timeout_plays", last_played, 8'h03);

        // Flush while a phoneme is held in progress.
        busy_mode = 2;
        wr(2'd1, 16'h0002);
        for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
        n0 = n_starts;
        wr(2'd1, 16'h0000);
        repeat (10) @(negedge clk);
        check("flush_one_started", n_starts - n0, 1);
        rd(2'd0, r);
        check_stat("status_before_flush", r, stat(5, 1, 0, 0));
        wr(2'd1, 16'h0001);
        exp_q.delete();
        rd(2'd0, r);
        check_stat("status_after_flush", r, stat(0, 1, 0, 0));
        busy_mode = 1;
        repeat (30) @(negedge clk);
        check("flush_no_more_starts", n_starts - n0, 1);
        rd(2'd0, r);
        check_stat("status_flush_idle", r, 16'h4000);

        // Random mix of pushes and side-effect-free accesses.
        busy_mode = 0;
        for (int it = 0; it < 60; it++) begin
            k = int'($urandom_range(0, 9));
            if (k <= 6) begin
                push(8'($urandom));
            end else if (k == 7) begin
                rd(2'd2 + 2'($urandom_range(0, 1)), r);
                check("rand_read_unmapped", r, 16'h0000);
            end else if (k == 8) begin
                bus_cycle(1'b0, 2'd0, 16'($urandom), 1'b1, 1'b0, 1'b1, r);
            end else begin
                wr(2'd2 + 2'($urandom_range(0, 1)), 16'($urandom));
                rd(2'd1, r);
                check("rand_pause_readback", r, 16'h0000);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        drain();
        rd(2'd0, r);
        check_stat("status_after_random", r, 16'h4000);

`ifdef PHONEME_QUEUE_IRQ_EN
        rd(2'd0, r);
        check("irq_cleared_by_read", irq_l, 1'b1);
        push(8'h61);
        push(8'h62);
        drain();
        check("irq_after_drain", irq_l, 1'b0);
        rd(2'd0, r);
        check("status_irq_set", r, 16'h4800);
        check("irq_released", irq_l, 1'b1);
        rd(2'd0, r);
        check("status_irq_clear", r, 16'h4000);
`endif

        // Reset in the middle of a phoneme.
        busy_mode = 2;
        n0 = n_starts;
        push(8'h50);
        push(8'h51);
        repeat (10) @(negedge clk);
        check("pre_reset_started", n_starts - n0, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        busy_mode = 1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("no_start_after_reset", n_starts - n0, 1);
`ifdef PHONEME_QUEUE_IRQ_EN
        check("irq_after_reset", irq_l, 1'b1);
`endif
        rd(2'd0, r);
        check("status_after_mid_reset", r, 16'h4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
